// File: rtl/axi_mem_bridge_if.sv
// Signal bundle for axi_mem_bridge: the AXI3 slave channels plus the word-wide device port.
// The slave modport is the bridge; the master modport drives AXI and serves device reads.
interface axi_mem_bridge_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned ID_W   = 4,
    parameter int unsigned OFFS_W = 6
);
    logic [ID_W-1:0]     aw_id;
    logic [ADDR_W-1:0]   aw_addr;
    logic [3:0]          aw_len;
    logic [2:0]          aw_size;
    logic [1:0]          aw_burst;
    logic                aw_valid;
    logic                aw_ready;

    logic [ID_W-1:0]     w_id;
    logic [DATA_W-1:0]   w_data;
    logic [DATA_W/8-1:0] w_strb;
    logic                w_last;
    logic                w_valid;
    logic                w_ready;

    logic [ID_W-1:0]     b_id;
    logic [1:0]          b_resp;
    logic                b_valid;
    logic                b_ready;

    logic [ID_W-1:0]     ar_id;
    logic [ADDR_W-1:0]   ar_addr;
    logic [3:0]          ar_len;
    logic [2:0]          ar_size;
    logic [1:0]          ar_burst;
    logic                ar_valid;
    logic                ar_ready;

    logic [ID_W-1:0]     r_id;
    logic [DATA_W-1:0]   r_data;
    logic [1:0]          r_resp;
    logic                r_last;
    logic                r_valid;
    logic                r_ready;

    logic                d_wen;
    logic                d_ren;
    logic [OFFS_W-1:0]   d_offset;
    logic [DATA_W-1:0]   d_wdata;
    logic [DATA_W/8-1:0] d_strb;
    logic [DATA_W-1:0]   d_rdata;

    modport slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
        output aw_ready,
        input  w_id, w_data, w_strb, w_last, w_valid,
        output w_ready,
        output b_id, b_resp, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_valid,
        input  r_ready,
        output d_wen, d_ren, d_offset, d_wdata, d_strb,
        input  d_rdata
    );

    modport master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
        input  aw_ready,
        output w_id, w_data, w_strb, w_last, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_valid,
        output r_ready,
        input  d_wen, d_ren, d_offset, d_wdata, d_strb,
        output d_rdata
    );
endinterface

// File: rtl/axi_mem_bridge.sv
// AXI3 slave that turns one burst at a time into word accesses on a simple device port,
// round-robining between the write and read channels.
module axi_mem_bridge #(
    parameter int unsigned       DATA_W = 32,
    parameter int unsigned       ADDR_W = 32,
    parameter int unsigned       ID_W   = 4,
    parameter int unsigned       OFFS_W = 6,
    parameter logic [ADDR_W-1:0] BASE   = '0
) (
    input  logic            a_clk,
    input  logic            a_resetn,
    axi_mem_bridge_if.slave bus
);

    localparam int unsigned     BYTE_SH   = $clog2(DATA_W / 8);
    localparam longint unsigned WIN_BYTES = (64'd1 << OFFS_W) * 64'(DATA_W / 8);
    localparam logic            GRANT_RD  = 1'b0;
    localparam logic            GRANT_WR  = 1'b1;

    typedef enum logic [1:0] {StIdle, StWData, StWResp, StRData} state_t;

    state_t            r_state;
    logic              r_last_grant;
    logic [ID_W-1:0]   r_cap_id;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_len;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;
    logic [3:0]        r_beat_cnt;
    logic              r_err;

    logic              w_gnt_wr, w_gnt_rd;
    logic [ID_W-1:0]   w_a_id;
    logic [ADDR_W-1:0] w_a_addr;
    logic [3:0]        w_a_len;
    logic [2:0]        w_a_size;
    logic [1:0]        w_a_burst;
    logic              w_a_err;

    // Grant, request mux and burst-level legality of the request being accepted.
    always_comb begin
        w_gnt_wr = bus.aw_valid && (!bus.ar_valid || r_last_grant == GRANT_RD);
        w_gnt_rd = bus.ar_valid && (!bus.aw_valid || r_last_grant == GRANT_WR);
        if (w_gnt_wr) begin
            w_a_id    = bus.aw_id;
            w_a_addr  = bus.aw_addr;
            w_a_len   = bus.aw_len;
            w_a_size  = bus.aw_size;
            w_a_burst = bus.aw_burst;
        end else begin
            w_a_id    = bus.ar_id;
            w_a_addr  = bus.ar_addr;
            w_a_len   = bus.ar_len;
            w_a_size  = bus.ar_size;
            w_a_burst = bus.ar_burst;
        end
        w_a_err = (w_a_size > 3'(BYTE_SH)) || (w_a_burst == 2'b11);
        if (w_a_burst == 2'b10) begin
            if (!(w_a_len inside {4'd1, 4'd3, 4'd7, 4'd15})) w_a_err = 1'b1;
            if ((w_a_addr & ((ADDR_W'(1) << w_a_size) - ADDR_W'(1))) != '0) w_a_err = 1'b1;
        end
    end

    logic [ADDR_W-1:0] w_rel, w_step, w_wrap_mask, w_next_addr;
    logic              w_in_range, w_last_beat, w_w_hs, w_r_hs, w_id_ok, w_w_err;

    always_comb begin
        w_rel       = r_addr - BASE;
        w_in_range  = (r_addr >= BASE) && (64'(w_rel) < WIN_BYTES);
        w_step      = ADDR_W'(1) << r_size;
        w_wrap_mask = ((ADDR_W'(r_len) + ADDR_W'(1)) << r_size) - ADDR_W'(1);
        case (r_burst)
            2'b00:   w_next_addr = r_addr;
            2'b10:   w_next_addr = (r_addr & ~w_wrap_mask) | ((r_addr + w_step) & w_wrap_mask);
            default: w_next_addr = r_addr + w_step;
        endcase
        w_last_beat = (r_beat_cnt == r_len);
        w_w_hs      = (r_state == StWData) && bus.w_valid;
        w_r_hs      = (r_state == StRData) && bus.r_ready;
        w_id_ok     = (bus.w_id == r_cap_id);
        // Covers early w_last, missing w_last and beats past the end of the burst.
        w_w_err     = !w_in_range || !w_id_ok || (bus.w_last != w_last_beat);
    end

    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            r_state      <= StIdle;
            r_last_grant <= GRANT_RD;
            r_cap_id     <= '0;
            r_addr       <= '0;
            r_len        <= '0;
            r_size       <= '0;
            r_burst      <= '0;
            r_beat_cnt   <= '0;
            r_err        <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_gnt_wr || w_gnt_rd) begin
                        r_cap_id     <= w_a_id;
                        r_addr       <= w_a_addr;
                        r_len        <= w_a_len;
                        r_size       <= w_a_size;
                        r_burst      <= w_a_burst;
                        r_beat_cnt   <= '0;
                        r_err        <= w_a_err;
                        r_last_grant <= w_gnt_wr ? GRANT_WR : GRANT_RD;
                        r_state      <= w_gnt_wr ? StWData : StRData;
                    end
                end
                StWData: begin
                    if (w_w_hs) begin
                        r_beat_cnt <= r_beat_cnt + 4'd1;
                        r_addr     <= w_next_addr;
                        if (w_w_err) r_err <= 1'b1;
                        if (bus.w_last) r_state <= StWResp;
                    end
                end
                StWResp: begin
                    if (bus.b_ready) r_state <= StIdle;
                end
                StRData: begin
                    if (w_r_hs) begin
                        r_beat_cnt <= r_beat_cnt + 4'd1;
                        r_addr     <= w_next_addr;
                        if (w_last_beat) r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    always_comb begin
        bus.aw_ready = (r_state == StIdle) && w_gnt_wr;
        bus.ar_ready = (r_state == StIdle) && w_gnt_rd;
        bus.w_ready  = (r_state == StWData);
        bus.b_valid  = (r_state == StWResp);
        bus.b_id     = r_cap_id;
        bus.b_resp   = ((r_state == StWResp) && r_err) ? 2'b10 : 2'b00;
        bus.r_valid  = (r_state == StRData);
        bus.r_id     = r_cap_id;
        bus.r_last   = (r_state == StRData) && w_last_beat;
        bus.r_resp   = ((r_state == StRData) && (r_err || !w_in_range)) ? 2'b10 : 2'b00;
        bus.r_data   = ((r_state == StRData) && !r_err && w_in_range) ? bus.d_rdata : '0;
        bus.d_ren    = w_r_hs;
        bus.d_wen    = w_w_hs && !r_err && w_in_range && w_id_ok;
        // Never present a wrapped offset for a beat outside the window.
        bus.d_offset = (((r_state == StRData) || (r_state == StWData)) && w_in_range)
                       ? OFFS_W'(w_rel >> BYTE_SH) : '0;
        bus.d_wdata  = bus.w_data;
        bus.d_strb   = bus.w_strb;
    end

endmodule

// File: tb/tb_axi_mem_bridge.sv
// Directed bench for axi_mem_bridge: a 64-word memory model behind the device port,
// hand-computed expectations for each burst.
module tb_axi_mem_bridge;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic a_clk;
    logic a_resetn;
    logic do_preload;
    int   n_tests;
    int   n_fail;

    logic [31:0] mem [64];
    int unsigned wr_off[$];
    int unsigned rd_off[$];

    axi_mem_bridge_if #(.DATA_W(32), .ADDR_W(32), .ID_W(4), .OFFS_W(6)) bus ();

    axi_mem_bridge #(
        .DATA_W(32),
        .ADDR_W(32),
        .ID_W  (4),
        .OFFS_W(6),
        .BASE  (BASE)
    ) dut (
        .a_clk   (a_clk),
        .a_resetn(a_resetn),
        .bus     (bus.slave)
    );

    initial a_clk = 1'b0;
    always #5 a_clk = ~a_clk;

    assign bus.d_rdata = mem[bus.d_offset];

    always @(posedge a_clk) begin
        if (do_preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 + 32'(i);
        end else if (bus.d_wen) begin
            wr_off.push_back(32'(bus.d_offset));
            for (int b = 0; b < 4; b++)
                if (bus.d_strb[b]) mem[bus.d_offset][8*b +: 8] <= bus.d_wdata[8*b +: 8];
        end
        if (bus.d_ren) rd_off.push_back(32'(bus.d_offset));
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input logic preload);
        a_resetn   = 1'b0;
        do_preload = preload;
        repeat (2) @(negedge a_clk);
        a_resetn   = 1'b1;
        do_preload = 1'b0;
    endtask

    task automatic send_addr(input logic is_wr, input logic [3:0] id, input logic [31:0] addr,
                             input logic [3:0] len, input logic [2:0] size,
                             input logic [1:0] burst);
        int n = 0;
        @(negedge a_clk);
        if (is_wr) begin
            bus.aw_id = id; bus.aw_addr = addr; bus.aw_len = len;
            bus.aw_size = size; bus.aw_burst = burst; bus.aw_valid = 1'b1;
        end else begin
            bus.ar_id = id; bus.ar_addr = addr; bus.ar_len = len;
            bus.ar_size = size; bus.ar_burst = burst; bus.ar_valid = 1'b1;
        end
        #1;
        while (!(is_wr ? bus.aw_ready : bus.ar_ready) && n < 10) begin
            @(negedge a_clk); #1; n++;
        end
        check_eq(is_wr ? "aw_ready" : "ar_ready", is_wr ? bus.aw_ready : bus.ar_ready, 1);
        @(negedge a_clk);
        if (is_wr) bus.aw_valid = 1'b0;
        else       bus.ar_valid = 1'b0;
    endtask

    task automatic write_beat(input logic [3:0] id, input logic [31:0] data,
                              input logic [3:0] strb, input logic last);
        @(negedge a_clk);
        bus.w_id = id; bus.w_data = data; bus.w_strb = strb; bus.w_last = last;
        bus.w_valid = 1'b1;
        #1;
        check_eq("w_ready", bus.w_ready, 1);
    endtask

    task automatic wait_b(input logic [1:0] resp, input logic [3:0] id, input string tag);
        int n = 0;
        @(negedge a_clk);
        bus.w_valid = 1'b0; bus.w_last = 1'b0; bus.b_ready = 1'b1;
        #1;
        while (!bus.b_valid && n < 10) begin
            @(negedge a_clk); #1; n++;
        end
        check_eq({tag, "_b_latency"}, 64'(n), 0);
        check_eq({tag, "_b_valid"}, bus.b_valid, 1);
        check_eq({tag, "_b_resp"}, bus.b_resp, resp);
        check_eq({tag, "_b_id"}, bus.b_id, id);
        @(negedge a_clk);
        bus.b_ready = 1'b0;
    endtask

    task automatic read_beat(input logic [5:0] off, input logic [31:0] data,
                             input logic [1:0] resp, input logic last, input string tag);
        int n = 0;
        @(negedge a_clk);
        bus.r_ready = 1'b1;
        #1;
        while (!bus.r_valid && n < 10) begin
            @(negedge a_clk); #1; n++;
        end
        check_eq({tag, "_r_valid"}, bus.r_valid, 1);
        check_eq({tag, "_d_offset"}, bus.d_offset, off);
        check_eq({tag, "_r_data"}, bus.r_data, data);
        check_eq({tag, "_r_resp"}, bus.r_resp, resp);
        check_eq({tag, "_r_last"}, bus.r_last, last);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] wrap_data [4];
        logic [5:0]  wrap_off  [4];
        wrap_off  = '{6'd2, 6'd3, 6'd0, 6'd1};
        wrap_data = '{32'hA000_0002, 32'hA000_0003, 32'hA000_0000, 32'hA000_0001};
        n_tests = 0;
        n_fail  = 0;
        {bus.aw_id, bus.aw_addr, bus.aw_len, bus.aw_size, bus.aw_burst, bus.aw_valid} = '0;
        {bus.w_id, bus.w_data, bus.w_strb, bus.w_last, bus.w_valid} = '0;
        {bus.ar_id, bus.ar_addr, bus.ar_len, bus.ar_size, bus.ar_burst, bus.ar_valid} = '0;
        bus.b_ready = 1'b0;
        bus.r_ready = 1'b0;

        // Reset state
        do_reset(1'b1);
        #1;
        check_eq("rst_aw_ready", bus.aw_ready, 0);
        check_eq("rst_ar_ready", bus.ar_ready, 0);
        check_eq("rst_w_ready", bus.w_ready, 0);
        check_eq("rst_b_valid", bus.b_valid, 0);
        check_eq("rst_r_valid", bus.r_valid, 0);
        check_eq("rst_d_wen", bus.d_wen, 0);
        check_eq("rst_d_ren", bus.d_ren, 0);
        check_eq("rst_resps", {bus.b_resp, bus.r_resp, bus.r_last}, 0);
        check_eq("rst_ids", {bus.b_id, bus.r_id}, 0);
        check_eq("rst_d_offset", bus.d_offset, 0);

        // INCR write of 1..4 at BASE+0x10
        wr_off.delete();
        send_addr(1'b1, 4'd5, BASE + 32'h10, 4'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) write_beat(4'd5, 32'(i + 1), 4'hF, i == 3);
        wait_b(2'b00, 4'd5, "wr_incr");
        check_eq("wr_incr_count", 64'(wr_off.size()), 4);
        for (int i = 0; i < 4; i++) begin
            check_eq("wr_incr_offset", 64'(wr_off[i]), 64'(4 + i));
            check_eq("wr_incr_mem", mem[4 + i], 64'(i + 1));
        end

        // WRAP read from BASE+0x08: offsets 2,3,0,1
        rd_off.delete();
        send_addr(1'b0, 4'd3, BASE + 32'h08, 4'd3, 3'd2, 2'b10);
        for (int i = 0; i < 4; i++) read_beat(wrap_off[i], wrap_data[i], 2'b00, i == 3, "rd_wrap");
        @(negedge a_clk);
        bus.r_ready = 1'b0;
        #1;
        check_eq("rd_wrap_idle", bus.r_valid, 0);
        check_eq("rd_wrap_ren_count", 64'(rd_off.size()), 4);

        // w_id mismatch on the second beat
        wr_off.delete();
        send_addr(1'b1, 4'd6, BASE + 32'h20, 4'd1, 3'd2, 2'b01);
        write_beat(4'd6, 32'h11, 4'hF, 1'b0);
        write_beat(4'd7, 32'h22, 4'hF, 1'b1);
        wait_b(2'b10, 4'd6, "wr_idmis");
        check_eq("wr_idmis_count", 64'(wr_off.size()), 1);
        check_eq("wr_idmis_offset", 64'(wr_off[0]), 8);
        check_eq("wr_idmis_mem8", mem[8], 32'h11);
        check_eq("wr_idmis_mem9", mem[9], 32'hA000_0009);

        // INCR read crossing the top of the window
        rd_off.delete();
        send_addr(1'b0, 4'd8, BASE + 32'hFC, 4'd1, 3'd2, 2'b01);
        read_beat(6'd63, 32'hA000_003F, 2'b00, 1'b0, "rd_edge1");
        read_beat(6'd0, 32'h0, 2'b10, 1'b1, "rd_edge2");
        @(negedge a_clk);
        bus.r_ready = 1'b0;
        check_eq("rd_edge_first_offset", 64'(rd_off[0]), 63);

        // Reserved burst type: error beat with zero data
        send_addr(1'b0, 4'd4, BASE, 4'd0, 3'd2, 2'b11);
        read_beat(6'd0, 32'h0, 2'b10, 1'b1, "rd_badburst");
        @(negedge a_clk);
        bus.r_ready = 1'b0;

        // Simultaneous requests after reset: write, read, write
        do_reset(1'b0);
        @(negedge a_clk);
        bus.aw_id = 4'd1; bus.aw_addr = BASE; bus.aw_len = 4'd0;
        bus.aw_size = 3'd2; bus.aw_burst = 2'b01;
        bus.ar_id = 4'd2; bus.ar_addr = BASE + 32'h4; bus.ar_len = 4'd0;
        bus.ar_size = 3'd2; bus.ar_burst = 2'b01;
        bus.aw_valid = 1'b1; bus.ar_valid = 1'b1;
        #1;
        check_eq("arb1_aw_ready", bus.aw_ready, 1);
        check_eq("arb1_ar_ready", bus.ar_ready, 0);
        @(negedge a_clk);
        bus.aw_valid = 1'b0;
        write_beat(4'd1, 32'hDEAD_0000, 4'hF, 1'b1);
        wait_b(2'b00, 4'd1, "arb_w1");
        bus.aw_valid = 1'b1;
        #1;
        check_eq("arb2_ar_ready", bus.ar_ready, 1);
        check_eq("arb2_aw_ready", bus.aw_ready, 0);
        @(negedge a_clk);
        bus.ar_valid = 1'b0;
        read_beat(6'd1, 32'hA000_0001, 2'b00, 1'b1, "arb_r");
        @(negedge a_clk);
        bus.r_ready = 1'b0;
        bus.aw_id = 4'd3; bus.aw_addr = BASE + 32'h8;
        bus.ar_valid = 1'b1;
        #1;
        check_eq("arb3_aw_ready", bus.aw_ready, 1);
        check_eq("arb3_ar_ready", bus.ar_ready, 0);
        @(negedge a_clk);
        bus.aw_valid = 1'b0;
        bus.ar_valid = 1'b0;
        write_beat(4'd3, 32'h33, 4'hF, 1'b1);
        wait_b(2'b00, 4'd3, "arb_w3");
        check_eq("arb_mem0", mem[0], 32'hDEAD_0000);

        // r_ready stall mid-burst, then asynchronous reset
        send_addr(1'b0, 4'd9, BASE, 4'd3, 3'd2, 2'b01);
        read_beat(6'd0, 32'hDEAD_0000, 2'b00, 1'b0, "rd_stall1");
        @(negedge a_clk);
        bus.r_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("stall_r_valid", bus.r_valid, 1);
            check_eq("stall_r_data", bus.r_data, 32'hA000_0001);
            check_eq("stall_r_resp", bus.r_resp, 2'b00);
            check_eq("stall_r_last", bus.r_last, 0);
            @(negedge a_clk);
        end
        #2;
        a_resetn = 1'b0;
        #1;
        check_eq("arst_r_valid", bus.r_valid, 0);
        check_eq("arst_b_valid", bus.b_valid, 0);
        check_eq("arst_readies", {bus.aw_ready, bus.ar_ready, bus.w_ready}, 0);
        check_eq("arst_strobes", {bus.d_wen, bus.d_ren}, 0);
        check_eq("arst_r_last", bus.r_last, 0);
        @(negedge a_clk);
        a_resetn = 1'b1;
        bus.ar_id = 4'd0; bus.ar_addr = BASE; bus.ar_len = 4'd0;
        bus.ar_valid = 1'b1;
        #1;
        check_eq("arst_idle_ar_ready", bus.ar_ready, 1);
        bus.ar_valid = 1'b0;
        @(negedge a_clk);
        #1;
        check_eq("arst_no_resume", bus.r_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
